// File: rtl/mlp_input_loader.sv
// Stream-to-buffer loader for the quantized MLP core: assembles an IN_DIM-byte frame, launches the MLP, waits for done.
// Optional macro MLP_LOADER_ZP_EN: store incoming bytes as (pixel - 128) instead of raw int8.
module mlp_input_loader #(
    parameter int IN_DIM = 64,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [8*IN_DIM-1:0]   x_out,
    output logic                  mlp_start,
    input  logic                  mlp_done,
    output logic                  frame_err,
    output logic                  busy,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int IDX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_DIM - 1);

    typedef enum logic [1:0] {FILL, DRAIN, LAUNCH, BUSY} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [8*IN_DIM-1:0]  x_q, x_d;
    logic                 start_q, start_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic [7:0]           byte_in;

    always_comb begin
`ifdef MLP_LOADER_ZP_EN
        byte_in = s_data ^ 8'h80;
`else
        byte_in = s_data;
`endif
    end

    always_comb begin
        s_ready = rst_n && (state_q == FILL || state_q == DRAIN);
        accept  = s_valid && s_ready;
        busy    = (state_q == LAUNCH) || (state_q == BUSY);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        done_d  = done_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    x_d[{idx_q, 3'b000} +: 8] = byte_in;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            state_d = LAUNCH;
                            start_d = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            err_d   = 1'b1;
                        end
                    end else if (s_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) state_d = FILL;
            end
            LAUNCH: begin
                done_d  = 1'b1;
                state_d = BUSY;
            end
            BUSY: begin
                // Rising edge only, so a done level left over from the last run is not taken as completion.
                done_d = mlp_done;
                if (mlp_done && !done_q) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            x_q     <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            start_q <= start_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        x_out     = x_q;
        mlp_start = start_q;
        frame_err = err_q;
        frame_cnt = cnt_q;
    end

endmodule

// File: tb/tb_mlp_input_loader.sv
// Bench for mlp_input_loader: table of frame scenarios plus stale-done and mid-frame reset sequences.
module tb_mlp_input_loader;

    localparam int IN_DIM = 64;
    localparam int CNT_W  = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 s_valid;
    logic [7:0]           s_data;
    logic                 s_last;
    logic                 s_ready;
    logic [8*IN_DIM-1:0]  x_out;
    logic                 mlp_start;
    logic                 mlp_done;
    logic                 frame_err;
    logic                 busy;
    logic [CNT_W-1:0]     frame_cnt;

    mlp_input_loader #(.IN_DIM(IN_DIM), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .x_out(x_out), .mlp_start(mlp_start), .mlp_done(mlp_done),
        .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned start_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned exp_cnt = 0;
    logic [8*IN_DIM-1:0] exp_q[$];

    typedef struct {
        int unsigned len;
        int unsigned mode;
        bit          gap;
        int unsigned hold;
        bit          exp_launch;
        bit          exp_err;
        int unsigned err_at;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_x(input string name, input logic [8*IN_DIM-1:0] act, input logic [8*IN_DIM-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int unsigned mode, input int unsigned i);
        case (mode)
            0: gen = 8'(i);
            1: gen = 8'h7F;
            2: gen = 8'(i * 37 + 5);
            default: begin
                case (i)
                    0: gen = 8'h00;
                    1: gen = 8'h80;
                    2: gen = 8'hFF;
                    default: gen = 8'(i);
                endcase
            end
        endcase
    endfunction

    function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef MLP_LOADER_ZP_EN
        conv = b ^ 8'h80;
`else
        conv = b;
`endif
    endfunction

    function automatic logic [8*IN_DIM-1:0] build_x(input int unsigned mode);
        logic [8*IN_DIM-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < IN_DIM; i++) v[8*i +: 8] = conv(gen(mode, i));
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] d, input bit last);
        int unsigned guard;
        guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: s_ready stuck at %0b, required 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int unsigned mode, input int unsigned len);
        for (int unsigned i = 0; i < len; i++) send_byte(gen(mode, i), i == len - 1);
    endtask

    // Holds off done while probing with stray bytes, then pulses done once.
    task automatic run_busy(input int unsigned hold, input logic [8*IN_DIM-1:0] ex);
        int unsigned bad;
        bad = 0;
        for (int unsigned h = 0; h < hold; h++) begin
            s_valid = 1'b1;
            s_data  = 8'hAA;
            s_last  = 1'b1;
            @(negedge clk);
            if (!busy || s_ready || mlp_start) bad++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("busy_hold", bad, 0);
        chk_x("x_stable_busy", x_out, ex);
        mlp_done = 1'b1;
        @(negedge clk);
        mlp_done = 1'b0;
        exp_cnt++;
        chk("frame_cnt_after_done", 32'(frame_cnt), exp_cnt);
        chk("ready_after_done", s_ready, 1);
        chk("busy_after_done", busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mlp_start && frame_err) chk("start_err_overlap", 1, 0);
            if (frame_err) err_cnt++;
            if (mlp_start) begin
                start_cnt++;
                if (exp_q.size() == 0) chk("unexpected_start", mlp_start, 0);
                else chk_x("x_at_start", x_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [8*IN_DIM-1:0] ex;
        int unsigned bad;

        vecs[0] = '{len: 64, mode: 0, gap: 0, hold: 5,   exp_launch: 1, exp_err: 0, err_at: 0};
        vecs[1] = '{len: 64, mode: 0, gap: 1, hold: 500, exp_launch: 1, exp_err: 0, err_at: 0};
        vecs[2] = '{len: 11, mode: 1, gap: 0, hold: 0,   exp_launch: 0, exp_err: 1, err_at: 10};
        vecs[3] = '{len: 64, mode: 1, gap: 0, hold: 4,   exp_launch: 1, exp_err: 0, err_at: 0};
        vecs[4] = '{len: 70, mode: 0, gap: 0, hold: 0,   exp_launch: 0, exp_err: 1, err_at: 63};
        vecs[5] = '{len: 64, mode: 2, gap: 1, hold: 3,   exp_launch: 1, exp_err: 0, err_at: 0};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; mlp_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", s_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", mlp_start, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        chk_x("rst_x", x_out, '0);

        for (int v = 0; v < 6; v++) begin
            ex = build_x(vecs[v].mode);
            if (vecs[v].exp_launch) exp_q.push_back(ex);
            for (int unsigned i = 0; i < vecs[v].len; i++) begin
                send_byte(gen(vecs[v].mode, i), i == vecs[v].len - 1);
                if (vecs[v].exp_err && i == vecs[v].err_at) chk("err_pulse", frame_err, 1);
                if (i == vecs[v].len - 1) chk("start_latency", mlp_start, 32'(vecs[v].exp_launch));
                if (vecs[v].gap) @(negedge clk);
            end
            if (vecs[v].exp_launch) begin
                run_busy(vecs[v].hold, ex);
            end else begin
                @(negedge clk);
                chk("ready_after_drop", s_ready, 1);
                if (vecs[v].len > IN_DIM) chk_x("x_after_drain", x_out, ex);
            end
        end

        // Stale done level across launch: only a fresh rising edge completes.
        mlp_done = 1'b1;
        ex = build_x(2);
        exp_q.push_back(ex);
        send_frame(2, IN_DIM);
        chk("stale_start", mlp_start, 1);
        repeat (3) @(negedge clk);
        mlp_done = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!busy || 32'(frame_cnt) != exp_cnt) bad++;
        end
        chk("stale_ignored", bad, 0);
        mlp_done = 1'b1;
        @(negedge clk);
        exp_cnt++;
        chk("stale_complete_cnt", 32'(frame_cnt), exp_cnt);
        chk("stale_complete_ready", s_ready, 1);
        repeat (5) @(negedge clk);
        chk("stale_single_inc", 32'(frame_cnt), exp_cnt);
        mlp_done = 1'b0;

        // Reset after 30 bytes: partial frame vanishes silently.
        for (int unsigned i = 0; i < 30; i++) send_byte(gen(0, i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("ready_forced_low", s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_x("midrst_x", x_out, '0);
        chk("midrst_err", frame_err, 0);
        chk("midrst_ready", s_ready, 1);
        chk("midrst_cnt", 32'(frame_cnt), 0);
        exp_cnt = 0;

        ex = build_x(3);
        exp_q.push_back(ex);
        send_frame(3, IN_DIM);
        chk("post_rst_start", mlp_start, 1);
`ifdef MLP_LOADER_ZP_EN
        chk("zp_byte0", x_out[7:0], 8'h80);
        chk("zp_byte1", x_out[15:8], 8'h00);
        chk("zp_byte2", x_out[23:16], 8'h7F);
`else
        chk("raw_byte0", x_out[7:0], 8'h00);
        chk("raw_byte1", x_out[15:8], 8'h80);
        chk("raw_byte2", x_out[23:16], 8'hFF);
`endif
        run_busy(3, ex);

        @(negedge clk);
        chk("start_total", start_cnt, 6);
        chk("err_total", err_cnt, 2);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mlp_input_loader.md
Name: mlp_input_loader

Overview:
- Upstream feeder for the quantized MLP core (mlp_top_q, IN_DIM=64, HID_DIM=8, OUT_DIM=10).
- Accepts one feature vector as a valid/ready byte stream framed by s_last, assembles it into an IN_DIM-entry signed int8 buffer, then issues a one-cycle start to the MLP.
- Holds the buffer stable and back-pressures the stream until the MLP reports done.
- Drops malformed frames and flags each with a one-cycle error pulse.

Parameters:
- IN_DIM, 64, number of int8 elements per frame; x_out entries.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_last  in  1  marks final byte of a frame; qualified by s_valid && s_ready
- s_ready  out  1  loader can accept a byte
- x_out  out  8 x IN_DIM  signed int8 buffer driving the MLP x_in
- mlp_start  out  1  one-cycle start pulse to the MLP
- mlp_done  in  1  MLP completion (pulse or level)
- frame_err  out  1  one-cycle pulse per dropped frame
- busy  out  1  high while MLP owns x_out (LAUNCH/BUSY)
- frame_cnt  out  CNT_W  number of completed inferences, wraps modulo 2^CNT_W

Behaviour:
- Single clock. Reset is synchronous, active-low: when rst_n is sampled low at a clk edge, all state resets.
- Reset values:
  - state=FILL, idx=0, every x_out entry=0.
  - mlp_start=0, frame_err=0, frame_cnt=0, done_q=1.
  - s_ready is forced 0 while rst_n is low.
- Handshake: a byte is accepted when s_valid && s_ready on a clk edge. s_ready is combinational from state: 1 in FILL/DRAIN, 0 otherwise.
- Reset mid-operation (any state) returns to FILL with the reset values above. A partial frame is lost silently; no frame_err.
- States:
  - FILL: an accepted byte writes x_out[idx]. Then:
    - s_last && idx<IN_DIM-1: frame_err=1 next cycle; idx<=0; stay FILL (short frame).
    - idx==IN_DIM-1 && s_last: idx<=0; go to LAUNCH.
    - idx==IN_DIM-1 && !s_last: frame_err=1 next cycle; idx<=0; go to DRAIN (long frame).
    - otherwise: idx<=idx+1.
  - DRAIN: accept and discard bytes; x_out is not written. An accepted s_last goes to FILL.
  - LAUNCH: mlp_start=1 for exactly this cycle; done_q<=1; go to BUSY.
  - BUSY: completion = mlp_done && !done_q, with done_q<=mlp_done every cycle. On completion: frame_cnt<=frame_cnt+1 (wraps); go to FILL.
    - A stale-high mlp_done left over from the previous run is therefore ignored until it falls and rises again.
- Latency:
  - Last byte accepted at edge N -> mlp_start high in cycle N+1.
  - Completion edge -> s_ready high the following cycle.
- x_out changes only on FILL writes and is stable from LAUNCH until return to FILL.
- busy = (state==LAUNCH || state==BUSY).
- frame_err and mlp_start are registered single-cycle pulses. They never assert together.
- Default data path: s_data is interpreted as two's-complement int8 and stored unchanged.

Optional Feature:
- Macro: MLP_LOADER_ZP_EN.
- Defined: s_data is treated as an unsigned pixel with zero point 128, and the stored value is s_data-128 as signed int8 (e.g. 0x00->-128, 0x80->0, 0xFF->127). The conversion is the XOR of bit 7; no saturation is needed.
- Undefined: the byte is stored raw.
- Control, timing and error behaviour are identical in both builds.

Test Plan:
- Reset, then stream bytes 0..63 back-to-back with s_last on byte 63:
  - mlp_start high exactly one cycle, one cycle after the last handshake.
  - x_out[i]=i; s_ready=0 and busy=1 until an mlp_done pulse.
  - After the pulse, frame_cnt=1 and s_ready=1.
- Same frame with s_valid toggling every other cycle and mlp_done held low for 500 cycles:
  - Identical x_out; no extra starts.
  - Bytes presented during BUSY are not accepted.
- Short frame (s_last on byte 10), then a full frame of 0x7F:
  - Exactly one frame_err pulse after byte 10; no mlp_start for the short frame.
  - The second frame launches with all x_out=127.
- Long frame of 70 bytes with s_last on byte 69:
  - frame_err pulses after byte 63; bytes 64..69 are discarded; no mlp_start.
  - The next 64-byte frame launches normally.
- mlp_done held high from before launch, dropped 3 cycles after mlp_start, re-raised 20 cycles later:
  - Completion only on the re-raise; frame_cnt increments exactly once.
- rst_n low for one cycle after 30 bytes of a frame:
  - x_out all 0, idx=0, no frame_err.
  - A fresh full frame then launches correctly.
  - With MLP_LOADER_ZP_EN defined, bytes 0x00/0x80/0xFF land as -128/0/127.
